// File: rtl/sd_sector_hexdump_pkg.sv
// Package sd_dump_pkg: shared types and constants for the sector hex dumper.
//   state_t    : top-level sequencer states
//   ASCII_*    : fixed characters used in the dump text
//   hex_ascii  : 4-bit nibble -> uppercase ASCII hex digit
package sd_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_ACK_HOLD,
    ST_EMIT,
    ST_TX_WAIT
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 8'h37)
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/sd_sector_hexdump_char_tx.sv
// hexdump_char_tx: single-character handshake towards UART_TX.
//   char_valid_i / char_i : character offered by the sequencer (taken when idle)
//   char_ready_o          : the accepted character has been sent (tx_done_i seen)
//   tx_dv_o / tx_byte_o   : one-cycle strobe and character to UART_TX
//   tx_done_i             : UART_TX done pulse; ignored unless a char is in flight
module hexdump_char_tx
  import sd_dump_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       char_valid_i,
  input  logic [7:0] char_i,
  output logic       char_ready_o,
  output logic       tx_dv_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_done_i
);

  logic in_flight;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_dv_o   <= 1'b0;
      tx_byte_o <= '0;
      in_flight <= 1'b0;
    end else begin
      tx_dv_o <= 1'b0;
      if (char_valid_i && !in_flight) begin
        tx_dv_o   <= 1'b1;
        tx_byte_o <= char_i;
        in_flight <= 1'b1;
      end else if (in_flight && tx_done_i) begin
        in_flight <= 1'b0;
      end
    end
  end

  assign char_ready_o = in_flight & tx_done_i;

endmodule

// File: rtl/sd_sector_hexdump.sv
// sd_sector_hexdump: consumes one sector from the SD-card byte handshake and
// emits it as an uppercase ASCII hex dump ("OOO: XX XX ... XX\r\n" per line).
//   clk_i, reset_i            : clock, synchronous active-high reset
//   start_i / busy_o          : start a dump at offset 0 / dump in progress
//   byte_i, byte_rdy_i        : sector byte and four-phase request from SdCardCtrl
//   byte_ack_o                : four-phase acknowledge to SdCardCtrl
//   tx_dv_o, tx_byte_o        : character strobe and value to UART_TX
//   tx_done_i                 : UART_TX done pulse
// Build option: define HEXDUMP_CHECKSUM_EN to append "S=HHHH\r\n" carrying the
// 16-bit sum of all sector bytes after the last data line.
module sd_sector_hexdump
  import sd_dump_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE     = 512,
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter int unsigned OFFSET_DIGITS  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       busy_o,
  input  logic [7:0] byte_i,
  input  logic       byte_rdy_i,
  output logic       byte_ack_o,
  output logic       tx_dv_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_done_i
);

  localparam int unsigned CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned OW = 4 * OFFSET_DIGITS;
  localparam int unsigned IW = 8;
  localparam logic [CW-1:0] LINE_MASK = CW'(BYTES_PER_LINE - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_SIZE - 1);

  state_t          state;
  logic [7:0]      cur_byte;
  logic [CW-1:0]   count;
  logic [OW-1:0]   offset;
  logic [IW-1:0]   char_idx;
`ifdef HEXDUMP_CHECKSUM_EN
  logic [15:0]     checksum;
  logic            trailer;
`endif

  logic            line_start, line_last, block_last;
  logic [IW-1:0]   prefix_len, seq_len, data_idx, dig_sel;
  logic [3:0]      off_nib;
  logic [7:0]      cur_char;
  logic            last_char;
  logic            char_valid, char_ready;

  assign line_start = (count & LINE_MASK) == '0;
  assign line_last  = (count & LINE_MASK) == LINE_MASK;
  assign block_last = (count == LAST_BYTE);
  assign char_valid = (state == ST_EMIT);

  // Per byte the character sequence is: optional line prefix (offset digits,
  // ':', ' '), then hi/lo nibble, then ' ' or CR LF. char_idx walks it.
  always_comb begin
    prefix_len = line_start ? IW'(OFFSET_DIGITS + 2) : '0;
    seq_len    = prefix_len + (line_last ? IW'(4) : IW'(3));
    data_idx   = char_idx - prefix_len;
    dig_sel    = IW'(OFFSET_DIGITS - 1) - char_idx;
    off_nib    = 4'(offset >> {dig_sel, 2'b00});
    last_char  = (char_idx == seq_len - IW'(1));
    cur_char   = ASCII_SP;
    if (line_start && char_idx < IW'(OFFSET_DIGITS))
      cur_char = hex_ascii(off_nib);
    else if (line_start && char_idx == IW'(OFFSET_DIGITS))
      cur_char = ASCII_COLON;
    else if (line_start && char_idx == IW'(OFFSET_DIGITS + 1))
      cur_char = ASCII_SP;
    else if (data_idx == IW'(0))
      cur_char = hex_ascii(cur_byte[7:4]);
    else if (data_idx == IW'(1))
      cur_char = hex_ascii(cur_byte[3:0]);
    else if (data_idx == IW'(2))
      cur_char = line_last ? ASCII_CR : ASCII_SP;
    else
      cur_char = ASCII_LF;
`ifdef HEXDUMP_CHECKSUM_EN
    if (trailer) begin
      last_char = (char_idx == IW'(7));
      case (char_idx[2:0])
        3'd0:    cur_char = ASCII_S;
        3'd1:    cur_char = ASCII_EQ;
        3'd2:    cur_char = hex_ascii(checksum[15:12]);
        3'd3:    cur_char = hex_ascii(checksum[11:8]);
        3'd4:    cur_char = hex_ascii(checksum[7:4]);
        3'd5:    cur_char = hex_ascii(checksum[3:0]);
        3'd6:    cur_char = ASCII_CR;
        default: cur_char = ASCII_LF;
      endcase
    end
`endif
  end

  hexdump_char_tx u_char_tx (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .char_valid_i (char_valid),
    .char_i       (cur_char),
    .char_ready_o (char_ready),
    .tx_dv_o      (tx_dv_o),
    .tx_byte_o    (tx_byte_o),
    .tx_done_i    (tx_done_i)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      byte_ack_o <= 1'b0;
      cur_byte   <= '0;
      count      <= '0;
      offset     <= '0;
      char_idx   <= '0;
`ifdef HEXDUMP_CHECKSUM_EN
      checksum   <= '0;
      trailer    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            busy_o   <= 1'b1;
            count    <= '0;
            offset   <= '0;
            char_idx <= '0;
`ifdef HEXDUMP_CHECKSUM_EN
            checksum <= '0;
            trailer  <= 1'b0;
`endif
            state    <= ST_WAIT_BYTE;
          end
        end
        ST_WAIT_BYTE: begin
          if (byte_rdy_i) begin
            cur_byte   <= byte_i;
            byte_ack_o <= 1'b1;
`ifdef HEXDUMP_CHECKSUM_EN
            checksum   <= checksum + {8'h00, byte_i};
`endif
            state      <= ST_ACK_HOLD;
          end
        end
        ST_ACK_HOLD: begin
          if (!byte_rdy_i) begin
            byte_ack_o <= 1'b0;
            char_idx   <= '0;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          state <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (char_ready) begin
            if (!last_char) begin
              char_idx <= char_idx + IW'(1);
              state    <= ST_EMIT;
            end
`ifdef HEXDUMP_CHECKSUM_EN
            else if (trailer) begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end else if (block_last) begin
              trailer  <= 1'b1;
              char_idx <= '0;
              state    <= ST_EMIT;
            end
`else
            else if (block_last) begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end
`endif
            else begin
              count <= count + CW'(1);
              if (line_last) offset <= offset + OW'(BYTES_PER_LINE);
              state <= ST_WAIT_BYTE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_hexdump.sv
module tb_sd_sector_hexdump;

  typedef struct packed {
    logic [7:0] ch;
    logic       eob;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       busy_o;
  logic [7:0] byte_i = '0;
  logic       byte_rdy_i = 1'b0;
  logic       byte_ack_o;
  logic       tx_dv_o;
  logic [7:0] tx_byte_o;
  logic       tx_done_i = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   chars_seen = 0;
  int   bytes_done = 0;
  int   last_done_cyc = 0;
  logic [7:0] last_char = '0;
  exp_t sb[$];

  logic [7:0] bfm_data [512];
  bit   bfm_en = 1'b0;
  bit   spur_mode = 1'b0;
  int   uart_delay = 10;
  int   hold_cycles = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sd_sector_hexdump #(
    .BLOCK_SIZE     (512),
    .BYTES_PER_LINE (16),
    .OFFSET_DIGITS  (3)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .byte_i     (byte_i),
    .byte_rdy_i (byte_rdy_i),
    .byte_ack_o (byte_ack_o),
    .tx_dv_o    (tx_dv_o),
    .tx_byte_o  (tx_byte_o),
    .tx_done_i  (tx_done_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    else           return 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push(input logic [7:0] c, input logic eob);
    exp_t e;
    e.ch  = c;
    e.eob = eob;
    sb.push_back(e);
  endtask

  // Expected text of a full dump of bfm_data; eob marks the final char of
  // each byte except the last (used by the spurious-done responder).
  task automatic push_sector();
    logic [11:0] off;
    logic        not_last;
`ifdef HEXDUMP_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    for (int i = 0; i < 512; i++) begin
      not_last = (i != 511);
      if (i % 16 == 0) begin
        off = 12'(i);
        push(hexc(off[11:8]), 1'b0);
        push(hexc(off[7:4]), 1'b0);
        push(hexc(off[3:0]), 1'b0);
        push(8'h3A, 1'b0);
        push(8'h20, 1'b0);
      end
      push(hexc(bfm_data[i][7:4]), 1'b0);
      push(hexc(bfm_data[i][3:0]), 1'b0);
      if (i % 16 == 15) begin
        push(8'h0D, 1'b0);
        push(8'h0A, not_last);
      end else begin
        push(8'h20, not_last);
      end
`ifdef HEXDUMP_CHECKSUM_EN
      sum = sum + {8'h00, bfm_data[i]};
`endif
    end
`ifdef HEXDUMP_CHECKSUM_EN
    push(8'h53, 1'b0);
    push(8'h3D, 1'b0);
    push(hexc(sum[15:12]), 1'b0);
    push(hexc(sum[11:8]), 1'b0);
    push(hexc(sum[7:4]), 1'b0);
    push(hexc(sum[3:0]), 1'b0);
    push(8'h0D, 1'b0);
    push(8'h0A, 1'b0);
`endif
  endtask

  // UART_TX model: pop expected char on each strobe, done after uart_delay.
  exp_t ue;
  bit   u_abort;
  always begin
    @(negedge clk);
    if (tx_dv_o && !reset_i) begin
      ue = '0;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL extra_char: observed 0x%02h expected no char", tx_byte_o);
      end
      if (sb.size() > 0) begin
        ue = sb.pop_front();
        chk("char", 32'(tx_byte_o), 32'(ue.ch));
      end
      chars_seen++;
      last_char = tx_byte_o;
      u_abort = 1'b0;
      for (int d = 0; d < uart_delay; d++) begin
        @(negedge clk);
        if (reset_i) begin
          u_abort = 1'b1;
          break;
        end
        if (d == 0) chk("dv_one_cycle", 32'(tx_dv_o), 32'd0);
      end
      if (!u_abort) begin
        chk("byte_hold", 32'(tx_byte_o), 32'(ue.ch));
        tx_done_i = 1'b1;
        last_done_cyc = cyc;
        if (ue.eob) bytes_done++;
        @(negedge clk);
        tx_done_i = 1'b0;
        if (spur_mode && ue.eob) begin
          @(negedge clk);
          tx_done_i = 1'b1;
          @(negedge clk);
          tx_done_i = 1'b0;
        end
      end
    end
  end

  // SdCardCtrl byte handshake BFM (four-phase).
  int  bfm_idx = 0;
  int  bytes_base = 0;
  int  bn;
  always begin
    @(negedge clk);
    if (!bfm_en) begin
      bfm_idx    = 0;
      byte_rdy_i = 1'b0;
      bytes_base = bytes_done;
    end else if (bfm_idx < 512) begin
      if (spur_mode) begin
        bn = 0;
        while (bfm_en && (bytes_done - bytes_base) < bfm_idx && bn < 5000) begin
          @(negedge clk);
          bn++;
        end
        if (bn >= 5000) chk("spur_wait_timeout", 32'(bn), 32'd0);
        repeat (6) @(negedge clk);
      end
      if (bfm_en) begin
        chk("ack_low_before_rdy", 32'(byte_ack_o), 32'd0);
        byte_i     = bfm_data[bfm_idx];
        byte_rdy_i = 1'b1;
        bn = 0;
        while (bfm_en && !byte_ack_o && bn < 5000) begin
          @(negedge clk);
          bn++;
        end
        if (bn >= 5000) chk("ack_rise_timeout", 32'(bn), 32'd0);
      end
      if (bfm_en) begin
        for (int h = 0; h < ((bfm_idx < 128) ? hold_cycles : 0); h++) begin
          @(negedge clk);
          if (!bfm_en) break;
          chk("ack_held", 32'(byte_ack_o), 32'd1);
        end
      end
      byte_rdy_i = 1'b0;
      if (bfm_en) begin
        bn = 0;
        while (bfm_en && byte_ack_o && bn < 100) begin
          @(negedge clk);
          bn++;
        end
        if (bn >= 100) chk("ack_fall_timeout", 32'(bn), 32'd0);
        bfm_idx++;
      end
    end
  end

  task automatic start_dump();
    bfm_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("ack_idle_ignores_rdy", 32'(byte_ack_o), 32'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic finish_dump(input int base, input int exp_n);
    int n;
    n = 0;
    while (busy_o && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop_timeout", 32'(n < 60000), 32'd1);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    chk("char_count", 32'(chars_seen - base), 32'(exp_n));
    chk("busy_drop_latency", 32'(cyc - last_done_cyc), 32'd1);
    chk("last_char_lf", 32'(last_char), 32'h0A);
    bfm_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("ack_low_after_dump", 32'(byte_ack_o), 32'd0);
  endtask

  task automatic run_dump(input int extra_start_at);
    int base, exp_n;
    push_sector();
    exp_n = sb.size();
    base  = chars_seen;
    start_dump();
    if (extra_start_at > 0) begin
      repeat (extra_start_at) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    finish_dump(base, exp_n);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ack", 32'(byte_ack_o), 32'd0);
    chk("rst_dv", 32'(tx_dv_o), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte_o), 32'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // 1: counting pattern, slow UART
    for (int i = 0; i < 512; i++) bfm_data[i] = 8'(i);
    uart_delay = 10;
    run_dump(0);

    // 2: requester holds byte_rdy_i long after the ack
    uart_delay  = 2;
    hold_cycles = 20;
    run_dump(0);
    hold_cycles = 0;

    // 3: start_i while busy is ignored
    run_dump(100);

    // 4: reset in the middle of line 5, then a clean dump
    push_sector();
    n = chars_seen;
    start_dump();
    while ((chars_seen - n) < (5 * 54 + 20) && (cyc < 90000)) @(negedge clk);
    chk("mid_line5_reached", 32'(chars_seen - n >= 5 * 54 + 20), 32'd1);
    reset_i = 1'b1;
    bfm_en  = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ack", 32'(byte_ack_o), 32'd0);
    chk("midrst_dv", 32'(tx_dv_o), 32'd0);
    chk("midrst_tx_byte", 32'(tx_byte_o), 32'd0);
    reset_i = 1'b0;
    sb.delete();
    repeat (5) @(negedge clk);
    run_dump(0);

    // 5: random data with spurious tx_done_i while waiting for a byte
    for (int i = 0; i < 512; i++) bfm_data[i] = 8'($urandom_range(0, 255));
    spur_mode = 1'b1;
    run_dump(0);
    spur_mode = 1'b0;

    // 6: all-ones sector
    for (int i = 0; i < 512; i++) bfm_data[i] = 8'hFF;
    run_dump(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
